// File: rtl/commit_pc_buffer.sv
// Dual-lane retire PC buffer that reorders nothing: it compacts up to two PCs per cycle into a circular store and drains up to two per cycle.
// Latency: one cycle from acceptance to out_pc*, with no bypass. Backpressure: in_ready drops when fewer than two slots are free, and out_ready gates dequeue.
// Optional: define COMMIT_PC_STALL_CNT_EN to add the stall_cycles counter output.
module commit_pc_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid1,
    input  logic [DATA_WIDTH-1:0]  in_pc1,
    input  logic                   in_valid2,
    input  logic [DATA_WIDTH-1:0]  in_pc2,
    output logic                   in_ready,
    input  logic                   out_ready,
    output logic                   out_wen1,
    output logic [DATA_WIDTH-1:0]  out_pc1,
    output logic                   out_wen2,
    output logic [DATA_WIDTH-1:0]  out_pc2,
    output logic [$clog2(DEPTH):0] count
`ifdef COMMIT_PC_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH - 2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         cnt;
    logic                  accept;
    logic [1:0]            n_enq;
    logic [1:0]            n_deq;

    // Readiness looks only at the registered occupancy so a dequeue in the same cycle never opens the gate.
    assign accept   = rst && (cnt <= FILL_MAX);
    assign in_ready = accept;
    assign out_wen1 = rst && out_ready && (cnt != '0);
    assign out_wen2 = rst && out_ready && (cnt > CW'(1));
    assign out_pc1  = out_wen1 ? mem[rd_ptr] : '0;
    assign out_pc2  = out_wen2 ? mem[rd_ptr + PW'(1)] : '0;
    assign count    = rst ? cnt : '0;
    assign n_enq    = accept ? ({1'b0, in_valid1} + {1'b0, in_valid2}) : 2'd0;
    assign n_deq    = {1'b0, out_wen1} + {1'b0, out_wen2};

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(n_deq);
            wr_ptr <= wr_ptr + PW'(n_enq);
            cnt    <= cnt + CW'(n_enq) - CW'(n_deq);
        end
    end

    // Storage is never cleared; occupancy alone decides which slots are visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (in_valid1) mem[wr_ptr] <= in_pc1;
            if (in_valid2) mem[in_valid1 ? wr_ptr + PW'(1) : wr_ptr] <= in_pc2;
        end
    end

`ifdef COMMIT_PC_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (!accept && (in_valid1 || in_valid2)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
